wrapping_step_counter: RTL

Up/down modulo-RANGE counter with per-cycle variable step sizes, synchronous load, optional saturating mode and registered wrap/saturation event flags. It generalises the single-step wrapping counter for pointer arithmetic in multi-entry FIFOs, credit counters and ring-buffer indexing, where several entries are pushed or popped per cycle. All outputs come directly from registers except the combinational max/min status flags.

---
 rtl/wrapping_step_counter_pkg.sv | 9 +
 rtl/wrapping_step_counter_adder.sv | 40 ++++
 rtl/wrapping_step_counter.sv | 74 +++++++
 3 files changed

// File: rtl/wrapping_step_counter_pkg.sv
// Shared definitions for the step counter and its adder.
package wrapping_step_counter_pkg;

   typedef enum logic {
      WRAP_MODE     = 1'b0,
      SATURATE_MODE = 1'b1
   } count_mode_t;

endpackage

// File: rtl/wrapping_step_counter_adder.sv
// Combinational modulo-RANGE add/subtract with wrap or clamp correction.
// Reusable by any pointer logic that needs count + inc - dec kept inside [0, RANGE-1].
module wrapping_step_adder
   import wrapping_step_counter_pkg::*;
#(
   parameter int RANGE      = 10,
   parameter int RANGE_LOG2 = $clog2(RANGE)
) (
   input  logic [RANGE_LOG2-1:0] count,
   input  logic [RANGE_LOG2-1:0] inc,
   input  logic [RANGE_LOG2-1:0] dec,
   input  count_mode_t           mode,
   output logic [RANGE_LOG2-1:0] next_count,
   output logic                  wrap_up,
   output logic                  wrap_down
);

   localparam int SW = RANGE_LOG2 + 2;
   localparam logic signed [SW-1:0]         RANGE_S = SW'(RANGE);
   localparam logic [RANGE_LOG2-1:0]        MAX     = RANGE_LOG2'(RANGE - 1);

   logic signed [SW-1:0] sum;

   // Two extra bits hold both the sign and a carry up to 2*(RANGE-1).
   assign sum = $signed({2'b00, count}) + $signed({2'b00, inc}) - $signed({2'b00, dec});

   always_comb begin
      next_count = RANGE_LOG2'(sum);
      wrap_up    = 1'b0;
      wrap_down  = 1'b0;
      if (sum >= RANGE_S) begin
         wrap_up    = 1'b1;
         next_count = (mode == SATURATE_MODE) ? MAX : RANGE_LOG2'(sum - RANGE_S);
      end else if (sum < 0) begin
         wrap_down  = 1'b1;
         next_count = (mode == SATURATE_MODE) ? '0 : RANGE_LOG2'(sum + RANGE_S);
      end
   end

endmodule

// File: rtl/wrapping_step_counter.sv
// Up/down modulo-RANGE counter with variable steps, load priority and registered wrap flags.
// One-cycle update latency, no stall; max/min status decoded from the count register only.
module wrapping_step_counter
   import wrapping_step_counter_pkg::*;
#(
   parameter int RANGE       = 10,
   parameter int RANGE_LOG2  = $clog2(RANGE),
   parameter int RESET_VALUE = 0,
   parameter int SATURATE    = 0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  load,
   input  logic [RANGE_LOG2-1:0] load_value,
   input  logic                  increment,
   input  logic [RANGE_LOG2-1:0] increment_step,
   input  logic                  decrement,
   input  logic [RANGE_LOG2-1:0] decrement_step,
   output logic [RANGE_LOG2-1:0] count,
   output logic                  wrapped_up,
   output logic                  wrapped_down,
   output logic                  count_is_max,
   output logic                  count_is_min
);

   localparam logic [RANGE_LOG2-1:0] MAX     = RANGE_LOG2'(RANGE - 1);
   localparam logic [RANGE_LOG2-1:0] RST_CNT = RANGE_LOG2'(RESET_VALUE);
   localparam count_mode_t           MODE    = (SATURATE != 0) ? SATURATE_MODE : WRAP_MODE;

   logic [RANGE_LOG2-1:0] inc;
   logic [RANGE_LOG2-1:0] dec;
   logic [RANGE_LOG2-1:0] load_clamped;
   logic [RANGE_LOG2-1:0] next_count;
   logic                  wrap_up;
   logic                  wrap_down;

   // Out-of-range operands are pinned to RANGE-1 so the adder's single correction holds.
   assign inc          = increment ? ((increment_step > MAX) ? MAX : increment_step) : '0;
   assign dec          = decrement ? ((decrement_step > MAX) ? MAX : decrement_step) : '0;
   assign load_clamped = (load_value > MAX) ? MAX : load_value;

   wrapping_step_adder #(
      .RANGE      (RANGE),
      .RANGE_LOG2 (RANGE_LOG2)
   ) u_adder (
      .count      (count),
      .inc        (inc),
      .dec        (dec),
      .mode       (MODE),
      .next_count (next_count),
      .wrap_up    (wrap_up),
      .wrap_down  (wrap_down)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count        <= RST_CNT;
         wrapped_up   <= 1'b0;
         wrapped_down <= 1'b0;
      end else if (load) begin
         count        <= load_clamped;
         wrapped_up   <= 1'b0;
         wrapped_down <= 1'b0;
      end else begin
         count        <= next_count;
         wrapped_up   <= wrap_up;
         wrapped_down <= wrap_down;
      end
   end

   assign count_is_max = (count == MAX);
   assign count_is_min = (count == '0);

endmodule
